// File: rtl/lcd_dct_pkg.sv
// lcd_dct_pkg: shared widths and FSM state type for the DCT trace packer.
package lcd_dct_pkg;
    localparam int DCT_ATOM_W = 2;
    localparam int DCT_BUF_W = 30;
    localparam int DCT_CNT_W = 4;
    localparam int DCT_ATOMS_PER_WORD = DCT_BUF_W / DCT_ATOM_W;
    typedef enum logic [1:0] {RUN, DRAIN, ENDED} dct_state_t;
endpackage

// File: rtl/lcd_dct_out_reg.sv
// lcd_dct_out_reg: one-entry valid/ready holding register for {count, buffer}.
module lcd_dct_out_reg
    import lcd_dct_pkg::*;
#(
    parameter int W = DCT_CNT_W + DCT_BUF_W
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         ready,
    output logic [W-1:0] data,
    output logic         valid,
    output logic         out_free
);
    assign out_free = !valid || ready;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data  <= '0;
            valid <= 1'b0;
        end else begin
            if (load) data <= load_data;
            valid <= load || (valid && !ready);
        end
    end
endmodule

// File: rtl/lcd_dct_packer.sv
// lcd_dct_packer: packs 2-bit trace atoms into 15-atom DCT words with end-of-test flush.
// Optional stall statistics counter enabled by `define DCT_STALL_CNT_EN.
module lcd_dct_packer
    import lcd_dct_pkg::*;
#(
    parameter int ATOM_W = DCT_ATOM_W,
    parameter int BUF_W  = DCT_BUF_W,
    parameter int CNT_W  = DCT_CNT_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              atom_valid,
    input  logic [ATOM_W-1:0] atom_data,
    output logic              atom_ready,
    input  logic              test_ending,
    output logic [BUF_W-1:0]  dct_buffer,
    output logic [CNT_W-1:0]  dct_count,
    output logic              dct_valid,
    input  logic              dct_ready,
    output logic              test_has_ended,
    output logic [7:0]        stall_count
);
    localparam int APW = BUF_W / ATOM_W;
    logic [BUF_W-1:0] acc;
    logic [CNT_W-1:0] acc_cnt;
    dct_state_t state, state_nxt;
    logic out_free, acc_full, transfer, accept, drained;
    logic [CNT_W+BUF_W-1:0] out_word;
    assign acc_full = acc_cnt == CNT_W'(APW);
    assign transfer = out_free && (acc_full || (state == DRAIN && acc_cnt != '0));
    // Gated by reset_n so every output reads 0 while reset is asserted.
    assign atom_ready = reset_n && state == RUN && (!acc_full || out_free);
    assign accept = atom_valid && atom_ready;
    assign drained = acc_cnt == '0 && out_free;
    assign test_has_ended = state == ENDED;
    assign {dct_count, dct_buffer} = out_word;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= RUN;
            acc     <= '0;
            acc_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (transfer) begin
                acc     <= accept ? BUF_W'(atom_data) : '0;
                acc_cnt <= accept ? CNT_W'(1) : '0;
            end else if (accept) begin
                acc     <= {acc[BUF_W-ATOM_W-1:0], atom_data};
                acc_cnt <= acc_cnt + 1'b1;
            end
        end
    end
    // With nothing buffered, an end request completes without lingering in DRAIN.
    always_comb begin
        state_nxt = state;
        state_nxt = (state == RUN && test_ending) ? ((drained && !accept) ? ENDED : DRAIN)
                  : (state == DRAIN && drained) ? ENDED : state;
    end
    lcd_dct_out_reg #(.W(CNT_W + BUF_W)) u_out (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (transfer),
        .load_data ({acc_cnt, acc}),
        .ready     (dct_ready),
        .data      (out_word),
        .valid     (dct_valid),
        .out_free  (out_free)
    );
`ifdef DCT_STALL_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) stall_count <= '0;
        else if (state == RUN && atom_valid && !atom_ready && stall_count != 8'hFF)
            stall_count <= stall_count + 1'b1;
    end
`else
    assign stall_count = '0;
`endif
endmodule

// File: tb/tb_lcd_dct_packer.sv
// tb_lcd_dct_packer: directed self-checking bench for lcd_dct_packer.
module tb_lcd_dct_packer;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        atom_valid;
    logic [1:0]  atom_data;
    logic        atom_ready;
    logic        test_ending;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        dct_valid;
    logic        dct_ready;
    logic        test_has_ended;
    logic [7:0]  stall_count;
    int checks = 0;
    int errors = 0;
    logic [29:0] wq[$];
    logic [3:0]  cq[$];

    lcd_dct_packer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .atom_valid     (atom_valid),
        .atom_data      (atom_data),
        .atom_ready     (atom_ready),
        .test_ending    (test_ending),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .dct_valid      (dct_valid),
        .dct_ready      (dct_ready),
        .test_has_ended (test_has_ended),
        .stall_count    (stall_count)
    );

    always #5 clk = ~clk;

    // Inputs only change just after posedge, so the negedge view is the handshake of the next edge.
    always @(negedge clk) begin
        if (reset_n && dct_valid && dct_ready) begin
            wq.push_back(dct_buffer);
            cq.push_back(dct_count);
        end
    end

    function automatic logic [29:0] pack(input int start, input int n);
        int v = 0;
        for (int j = 0; j < n; j++) v = v * 4 + (start + j) % 4;
        return 30'(v);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        atom_valid = 1'b0;
        atom_data = 2'd0;
        test_ending = 1'b0;
        dct_ready = 1'b0;
        tick;
        reset_n = 1'b1;
        wq.delete();
        cq.delete();
    endtask

    task automatic feed(input int start, input int n);
        for (int j = 0; j < n; j++) begin
            atom_valid = 1'b1;
            atom_data = 2'((start + j) % 4);
            tick;
        end
        atom_valid = 1'b0;
    endtask

    task automatic wait_ended;
        for (int c = 0; c < 100 && !test_has_ended; c++) tick;
        checks++;
        if (test_has_ended !== 1'b1) begin
            errors++;
            $display("FAIL wait_ended: test_has_ended=%b required 1 within 100 cycles", test_has_ended);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        atom_valid = 1'b1;
        atom_data = 2'd3;
        test_ending = 1'b0;
        dct_ready = 1'b1;
        tick;
        tick;
        checks++;
        if ({dct_valid, dct_buffer, dct_count, atom_ready, test_has_ended, stall_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b buf=%h cnt=%0d ready=%b ended=%b stall=%0d required all 0",
                     dct_valid, dct_buffer, dct_count, atom_ready, test_has_ended, stall_count);
        end
        atom_valid = 1'b0;
        reset_n = 1'b1;
    endtask

    task automatic test_single_word;
        do_reset;
        dct_ready = 1'b1;
        feed(0, 15);
        checks++;
        if (dct_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_early: dct_valid=%b required 0", dct_valid);
        end
        tick;
        checks++;
        if (dct_valid !== 1'b1 || dct_buffer !== 30'h06C6C6C6 || dct_count !== 4'd15) begin
            errors++;
            $display("FAIL single_word: valid=%b buf=%h cnt=%0d required 1 06c6c6c6 15",
                     dct_valid, dct_buffer, dct_count);
        end
        tick;
        checks++;
        if (dct_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_consumed: dct_valid=%b required 0", dct_valid);
        end
    endtask

    task automatic test_continuous;
        int drops = 0;
        do_reset;
        dct_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            atom_valid = 1'b1;
            atom_data = 2'(i % 4);
            @(negedge clk);
            if (atom_ready !== 1'b1) drops++;
            tick;
        end
        atom_valid = 1'b0;
        checks++;
        if (drops !== 0) begin
            errors++;
            $display("FAIL cont_ready: atom_ready low in %0d cycles required 0", drops);
        end
        test_ending = 1'b1;
        tick;
        test_ending = 1'b0;
        wait_ended;
        checks++;
        if (wq.size() !== 3) begin
            errors++;
            $display("FAIL cont_words: got %0d words required 3", wq.size());
        end
        checks++;
        if (wq[0] !== pack(0, 15) || cq[0] !== 4'd15 || wq[1] !== pack(15, 15) || cq[1] !== 4'd15) begin
            errors++;
            $display("FAIL cont_full: w0=%h/%0d w1=%h/%0d required %h/15 %h/15",
                     wq[0], cq[0], wq[1], cq[1], pack(0, 15), pack(15, 15));
        end
        checks++;
        if (wq[2] !== pack(30, 10) || cq[2] !== 4'd10 || (wq[2] >> 20) !== 30'd0) begin
            errors++;
            $display("FAIL cont_partial: w2=%h/%0d required %h/10", wq[2], cq[2], pack(30, 10));
        end
    endtask

    task automatic test_backpressure;
        do_reset;
        feed(0, 30);
        atom_valid = 1'b1;
        atom_data = 2'd0;
        @(negedge clk);
        checks++;
        if (atom_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_ready: atom_ready=%b required 0", atom_ready);
        end
        #1;
        checks++;
        if (dct_valid !== 1'b1 || dct_buffer !== pack(0, 15) || dct_count !== 4'd15) begin
            errors++;
            $display("FAIL bp_hold: valid=%b buf=%h cnt=%0d required 1 %h 15",
                     dct_valid, dct_buffer, dct_count, pack(0, 15));
        end
        repeat (300) tick;
        checks++;
        if (dct_valid !== 1'b1 || dct_buffer !== pack(0, 15) || dct_count !== 4'd15) begin
            errors++;
            $display("FAIL bp_stable: valid=%b buf=%h cnt=%0d required 1 %h 15",
                     dct_valid, dct_buffer, dct_count, pack(0, 15));
        end
        checks++;
`ifdef DCT_STALL_CNT_EN
        if (stall_count !== 8'd255) begin
            errors++;
            $display("FAIL stall_count: got %0d required 255", stall_count);
        end
`else
        if (stall_count !== 8'd0) begin
            errors++;
            $display("FAIL stall_count: got %0d required 0", stall_count);
        end
`endif
        atom_valid = 1'b0;
        dct_ready = 1'b1;
        repeat (5) tick;
        checks++;
        if (wq.size() !== 2 || wq[0] !== pack(0, 15) || wq[1] !== pack(15, 15) || cq[1] !== 4'd15) begin
            errors++;
            $display("FAIL bp_order: n=%0d w0=%h w1=%h/%0d required 2 %h %h/15",
                     wq.size(), wq[0], wq[1], cq[1], pack(0, 15), pack(15, 15));
        end
    endtask

    task automatic test_end_same_cycle;
        do_reset;
        dct_ready = 1'b1;
        atom_valid = 1'b1;
        atom_data = 2'd3;
        test_ending = 1'b1;
        tick;
        atom_valid = 1'b0;
        test_ending = 1'b0;
        wait_ended;
        checks++;
        if (wq.size() !== 1 || wq[0] !== 30'd3 || cq[0] !== 4'd1) begin
            errors++;
            $display("FAIL end_word: n=%0d w0=%h/%0d required 1 00000003/1", wq.size(), wq[0], cq[0]);
        end
        atom_valid = 1'b1;
        test_ending = 1'b1;
        @(negedge clk);
        checks++;
        if (atom_ready !== 1'b0) begin
            errors++;
            $display("FAIL end_refuse: atom_ready=%b required 0", atom_ready);
        end
        tick;
        tick;
        checks++;
        if (test_has_ended !== 1'b1 || dct_valid !== 1'b0) begin
            errors++;
            $display("FAIL end_sticky: ended=%b valid=%b required 1 0", test_has_ended, dct_valid);
        end
        atom_valid = 1'b0;
        test_ending = 1'b0;
    endtask

    task automatic test_empty_drain;
        do_reset;
        test_ending = 1'b1;
        @(negedge clk);
        checks++;
        if (test_has_ended !== 1'b0) begin
            errors++;
            $display("FAIL empty_pre: test_has_ended=%b required 0", test_has_ended);
        end
        tick;
        test_ending = 1'b0;
        checks++;
        if (test_has_ended !== 1'b1) begin
            errors++;
            $display("FAIL empty_drain: test_has_ended=%b required 1", test_has_ended);
        end
    endtask

    task automatic test_reset_mid;
        do_reset;
        feed(0, 22);
        checks++;
        if (dct_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_pending: dct_valid=%b required 1", dct_valid);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({dct_valid, dct_buffer, dct_count, atom_ready, test_has_ended, stall_count} !== '0) begin
            errors++;
            $display("FAIL mid_async: valid=%b buf=%h cnt=%0d ready=%b ended=%b stall=%0d required all 0",
                     dct_valid, dct_buffer, dct_count, atom_ready, test_has_ended, stall_count);
        end
        tick;
        reset_n = 1'b1;
        dct_ready = 1'b1;
        wq.delete();
        cq.delete();
        repeat (20) tick;
        checks++;
        if (wq.size() !== 0 || dct_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_stale: words=%0d valid=%b required 0 0", wq.size(), dct_valid);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_single_word;
        test_continuous;
        test_backpressure;
        test_end_same_cycle;
        test_empty_drain;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lcd_dct_packer.md
# lcd_dct_packer

Producer side of the Nios II data-compression-trace (DCT) buffer interface. It collects 2-bit trace atoms from the trace source, packs up to 15 atoms into a 30-bit `dct_buffer` word with an atom count `dct_count`, and hands each word to the trace sink over a valid/ready handshake. On an end-of-test request it flushes any partial word and then raises a sticky `test_has_ended`.

## Interface
- `ATOM_W`, 2: bits per trace atom.
- `BUF_W`, 30: `dct_buffer` width. Atoms per word = `BUF_W/ATOM_W` = 15.
- `CNT_W`, 4: `dct_count` width. Must hold the atoms-per-word value.
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `atom_valid`  in  1  source presents an atom.
- `atom_data`  in  ATOM_W  trace atom.
- `atom_ready`  out  1  packer accepts the atom this cycle.
- `test_ending`  in  1  end-of-test request; level, sampled every cycle.
- `dct_buffer`  out  BUF_W  packed word, right-aligned.
- `dct_count`  out  CNT_W  number of valid atoms in `dct_buffer` (1..15).
- `dct_valid`  out  1  word available.
- `dct_ready`  in  1  sink takes the word.
- `test_has_ended`  out  1  sticky; all atoms delivered after `test_ending`.
- `stall_count`  out  8  stall statistics; see Configuration.

## Operation
- Two storage stages. The accumulator holds `acc[29:0]` and `acc_cnt` (0..15). The output register drives `dct_buffer`, `dct_count` and `dct_valid`.
- Atom accept: when `atom_valid && atom_ready`, `acc <= {acc[27:0], atom_data}` and `acc_cnt` is incremented. The first atom of a word therefore lands in the most significant valid position.
- Define `out_free = !dct_valid || dct_ready`.
- Transfer: occurs when `acc_cnt==15`, or when in DRAIN with `acc_cnt>0`, and `out_free` holds.
  - The output register loads `acc` and `acc_cnt`, and `dct_valid` is set to 1.
  - The accumulator clears.
  - If an atom is accepted in the same cycle, the accumulator instead becomes `{28'b0, atom_data}` with `acc_cnt` = 1.
- A partial word with count n occupies bits [2n-1:0]. Upper bits are zero.
- `dct_valid` clears on `dct_ready` unless a new transfer happens in the same cycle.
- `atom_ready = (state==RUN) && (acc_cnt<15 || out_free)`.
- State machine:
  - RUN: if `test_ending` is 1, go to DRAIN. An atom accepted in that same cycle is kept.
  - DRAIN: `atom_ready` is 0. Partial words are transferred as output frees. Go to ENDED when `acc_cnt==0` and (`!dct_valid`, or `dct_valid && dct_ready`).
  - ENDED: `test_has_ended` is 1 and `atom_ready` is 0. The state is held until reset. `test_ending` is ignored.
- A `test_ending` pulse of a single cycle is sufficient.

## Timing
- Reset values: every output is 0, state is RUN, the accumulator is empty.
- Latency: if the 15th atom is accepted at edge k, `dct_valid` is 1 after edge k+1, provided the output register was free.
- Full throughput: one atom per cycle is sustained while the sink holds `dct_ready=1`. There are no bubbles at word boundaries.
- Backpressure: with a full accumulator and `dct_valid && !dct_ready`, `atom_ready` is 0. The word, count and valid stay stable until accepted.
- Empty drain: if `test_ending` arrives with both stages empty, `test_has_ended` is 1 after the next edge.
- Reset mid-operation: buffered atoms are discarded and all outputs are 0 asynchronously.

## Configuration
- `DCT_STALL_CNT_EN` defined: `stall_count` is an 8-bit saturating counter (stops at 255). It increments on each cycle with `state==RUN && atom_valid && !atom_ready`.
- Macro undefined: `stall_count` is tied to 0 and no counter logic is instantiated.

## Structure
- Package `lcd_dct_pkg` holds:
  - the state enum (RUN, DRAIN, ENDED);
  - `DCT_ATOM_W`;
  - `DCT_BUF_W`;
  - `DCT_CNT_W`;
  - `DCT_ATOMS_PER_WORD`.
- Sub-module `lcd_dct_out_reg`: a one-entry valid/ready holding register for `{dct_count, dct_buffer}`. It exports `out_free`.

## Test plan
- 15 atoms 0,1,2,3,0,1,… back-to-back with `dct_ready=1` -> one word `dct_buffer=30'h06C6C6C6` (`00 01 10 11` repeated, MSB first), `dct_count=15`, `dct_valid` 1 cycle after the 15th accept.
- 40 atoms continuous, `dct_ready=1` -> words of count 15 and 15, `atom_ready` never drops; then `test_ending` -> partial word, count 10, bits [29:20]=0, then `test_has_ended`=1.
- 30 atoms with `dct_ready=0` -> first word held stable, `atom_ready`=0 after the 30th atom; raise `dct_ready` -> both words delivered in order.
- Atom 3 with `test_ending` in the same cycle, accumulator empty -> word `dct_buffer=3`, `dct_count=1`, then `test_has_ended`=1. Further atoms are refused.
- `reset_n` pulsed low while holding 7 atoms and a pending word -> all outputs 0 immediately, no stale word after release.
- With `DCT_STALL_CNT_EN`: hold a full stall for 300 cycles -> `stall_count`=255. Without the macro -> 0.
